// File: rtl/cnt_ctrl_pkg.sv
// rtl/cnt_ctrl_pkg.sv - shared state and command encodings for the counter sequencer
package cnt_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_PAUSE = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

endpackage

// File: rtl/cnt_core.sv
// rtl/cnt_core.sv - counter register with sync clear, enable and terminal compare
module cnt_core #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] tc_i,
    output logic [WIDTH-1:0] count_o,
    output logic             eq_tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign eq_tc_o = (count_q == tc_i);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// rtl/cnt_seq_ctrl.sv - command-driven START/PAUSE/STOP sequencer for an up-counter
// Optional auto-reload at terminal count is enabled by defining CNT_AUTO_RELOAD_EN.
module cnt_seq_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int               WIDTH  = 3,
    parameter logic [WIDTH-1:0] TC_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] tc_value,
`ifdef CNT_AUTO_RELOAD_EN
    input  logic             reload_en,
    output logic             wrap,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] tc_q;
    logic             acc;
    logic             latch_tc;
    logic             clr_cmd;
    logic             en;
    logic             eq_tc;
    logic             reload_on;
    logic             reload_hit;

    assign cmd_ready = !rst && (state_q != ST_DONE);
    assign acc       = cmd_valid && cmd_ready;

    // Commands are decoded ahead of the terminal compare so they always win.
    always_comb begin
        state_d    = state_q;
        latch_tc   = 1'b0;
        clr_cmd    = 1'b0;
        en         = 1'b0;
        reload_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc && cmd_op == OP_START) begin
                    state_d  = ST_RUN;
                    clr_cmd  = 1'b1;
                    latch_tc = 1'b1;
                end
            end
            ST_RUN: begin
                if (acc && cmd_op == OP_START) begin
                    clr_cmd  = 1'b1;
                    latch_tc = 1'b1;
                end else if (acc && cmd_op == OP_STOP) begin
                    state_d = ST_IDLE;
                    clr_cmd = 1'b1;
                end else if (acc && cmd_op == OP_PAUSE) begin
                    state_d = ST_PAUSE;
                end else if (eq_tc) begin
                    if (reload_on) begin
                        reload_hit = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    en = 1'b1;
                end
            end
            ST_PAUSE: begin
                if (acc && cmd_op == OP_START) begin
                    state_d = ST_RUN;
                end else if (acc && cmd_op == OP_STOP) begin
                    state_d = ST_IDLE;
                    clr_cmd = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            tc_q    <= TC_RST;
        end else begin
            state_q <= state_d;
            if (latch_tc) begin
                tc_q <= tc_value;
            end
        end
    end

`ifdef CNT_AUTO_RELOAD_EN
    logic reload_q;
    logic wrap_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= reload_hit;
            if (latch_tc) begin
                reload_q <= reload_en;
            end
        end
    end

    assign reload_on = reload_q;
    assign wrap      = wrap_q;
`else
    assign reload_on = 1'b0;
`endif

    cnt_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (clr_cmd | reload_hit),
        .en_i    (en),
        .tc_i    (tc_q),
        .count_o (count),
        .eq_tc_o (eq_tc)
    );

    assign busy   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign paused = (state_q == ST_PAUSE);
    assign done   = (state_q == ST_DONE);

endmodule
